// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone block-copy initiator.
package wb_copy_pkg;

    localparam int STATE_W         = 3;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RD_GAP = 3'd2,
        WR     = 3'd3,
        WR_GAP = 3'd4,
        DONE   = 3'd5
    } state_t;

    // States in which a bus access is being strobed.
    function automatic logic is_strobe_state(input state_t s);
        return (s == RD) || (s == WR);
    endfunction

    // States in which the bus cycle is held open.
    function automatic logic is_cycle_state(input state_t s);
        return (s == RD) || (s == RD_GAP) || (s == WR) || (s == WR_GAP);
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Loadable down-counter that flags an access which has waited too long for ack.
module wb_ack_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_r;

    // Countdown register: clear beats load, load beats decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The last waiting cycle is the one where the count sits at one.
    assign expire = en && (cnt_r == CNT_W'(1));

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone classic initiator copying len words from src to dst, one read then one write per word.
module wb_copy_master
    import wb_copy_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  xfer_count,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t                state_r, next_state_s;
    logic [ADDR_WIDTH-1:0] src_r, dst_r, adr_r, bus_adr_s;
    logic [LEN_WIDTH-1:0]  len_r, idx_r, xfer_count_r;
    logic [DATA_WIDTH-1:0] buf_r, dat_r;
    logic                  cyc_r, stb_r, we_r, busy_r, done_r, err_r;
    logic                  accept_s, tmr_load_s, tmr_clear_s, tmr_en_s, tmr_expire_s;

    assign accept_s = (state_r == IDLE) && start;

    // Next-state decode; ack always takes priority over an expiring timer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len != {LEN_WIDTH{1'b0}}) begin
                        next_state_s = RD;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            RD: begin
                if (wb_ack_i) begin
                    next_state_s = RD_GAP;
                end else if (tmr_expire_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RD;
                end
            end
            RD_GAP: next_state_s = WR;
            WR: begin
                if (wb_ack_i) begin
                    next_state_s = WR_GAP;
                end else if (tmr_expire_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = WR;
                end
            end
            WR_GAP: begin
                if (idx_r == len_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RD;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Timer control: reload on entry into a strobed state, count only while waiting.
    always_comb begin
        tmr_en_s    = is_strobe_state(state_r) && !wb_ack_i;
        tmr_load_s  = 1'b0;
        tmr_clear_s = (next_state_s == DONE);
        if (is_strobe_state(next_state_s) && (next_state_s != state_r)) begin
            tmr_load_s = 1'b1;
        end else begin
            tmr_load_s = 1'b0;
        end
    end

    // Address for the next bus state; the first read bypasses the not-yet-latched source.
    always_comb begin
        bus_adr_s = {ADDR_WIDTH{1'b0}};
        if (next_state_s == RD) begin
            if (state_r == IDLE) begin
                bus_adr_s = src_addr;
            end else begin
                bus_adr_s = src_r + ADDR_WIDTH'(idx_r);
            end
        end else if (next_state_s == WR) begin
            bus_adr_s = dst_r + ADDR_WIDTH'(idx_r);
        end else begin
            bus_adr_s = {ADDR_WIDTH{1'b0}};
        end
    end

    wb_ack_timer #(
        .CNT_W (TMR_W)
    ) u_ack_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear_s),
        .load     (tmr_load_s),
        .load_val (TMR_W'(TIMEOUT)),
        .en       (tmr_en_s),
        .expire   (tmr_expire_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latched request, word index, read buffer and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_r        <= {ADDR_WIDTH{1'b0}};
            dst_r        <= {ADDR_WIDTH{1'b0}};
            len_r        <= {LEN_WIDTH{1'b0}};
            idx_r        <= {LEN_WIDTH{1'b0}};
            xfer_count_r <= {LEN_WIDTH{1'b0}};
            buf_r        <= {DATA_WIDTH{1'b0}};
            err_r        <= 1'b0;
        end else if (accept_s) begin
            src_r        <= src_addr;
            dst_r        <= dst_addr;
            len_r        <= len;
            idx_r        <= {LEN_WIDTH{1'b0}};
            xfer_count_r <= {LEN_WIDTH{1'b0}};
            err_r        <= 1'b0;
        end else if ((state_r == RD) && wb_ack_i) begin
            buf_r <= wb_dat_i;
        end else if ((state_r == WR) && wb_ack_i) begin
            idx_r        <= idx_r + LEN_WIDTH'(1);
            xfer_count_r <= idx_r + LEN_WIDTH'(1);
        end else if (tmr_expire_s) begin
            err_r <= 1'b1;
        end
    end

    // Bus and handshake outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_r  <= 1'b0;
            stb_r  <= 1'b0;
            we_r   <= 1'b0;
            adr_r  <= {ADDR_WIDTH{1'b0}};
            dat_r  <= {DATA_WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            cyc_r  <= is_cycle_state(next_state_s);
            stb_r  <= is_strobe_state(next_state_s);
            we_r   <= (next_state_s == WR);
            adr_r  <= bus_adr_s;
            dat_r  <= (next_state_s == WR) ? buf_r : {DATA_WIDTH{1'b0}};
            busy_r <= (next_state_s != IDLE);
            done_r <= (next_state_s == DONE);
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign xfer_count = xfer_count_r;
    assign wb_cyc_o   = cyc_r;
    assign wb_stb_o   = stb_r;
    assign wb_we_o    = we_r;
    assign wb_adr_o   = adr_r;
    assign wb_dat_o   = dat_r;

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master with a behavioural Wishbone responder and a write/read scoreboard.
module tb_wb_copy_master;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done, err;
    logic [15:0] xfer_count;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        ack_r  = 1'b0;
    logic        held_r = 1'b0;

    // responder controls, set by the stimulus
    logic hold_mode   = 1'b0;
    int   withhold_at = -1;

    // responder logs
    logic [31:0] rd_log     [0:63];
    logic [31:0] wr_adr_log [0:63];
    logic [31:0] wr_dat_log [0:63];
    int rd_cnt = 0;
    int wr_cnt = 0;

    int checks   = 0;
    int failures = 0;
    int rd_base, wr_base;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];

    // results of the last run
    int   r_done_cyc, r_busy_cyc, r_stb_rise, r_stb_fall;
    logic r_cyc_seen, r_busy_after, r_rst_cyc, r_rst_busy, r_rst_done;

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    assign wb_dat_i = pat(wb_adr_o);

    wb_copy_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LEN_WIDTH  (16),
        .TIMEOUT    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .xfer_count (xfer_count),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (ack_r)
    );

    // Responder: one wait state, optional ack hold-over and optional withheld read.
    always @(posedge clk) begin
        if (ack_r) begin
            if (hold_mode && !held_r) begin
                ack_r  <= 1'b1;
                held_r <= 1'b1;
            end else begin
                ack_r  <= 1'b0;
                held_r <= 1'b0;
            end
        end else if (wb_cyc_o && wb_stb_o && !(!wb_we_o && (rd_cnt == withhold_at))) begin
            ack_r  <= 1'b1;
            held_r <= 1'b0;
        end else begin
            ack_r  <= 1'b0;
            held_r <= 1'b0;
        end
        if (wb_cyc_o && wb_stb_o && ack_r) begin
            if (wb_we_o) begin
                wr_adr_log[wr_cnt[5:0]] <= wb_adr_o;
                wr_dat_log[wr_cnt[5:0]] <= wb_dat_o;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_log[rd_cnt[5:0]] <= wb_adr_o;
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(32'(s + 32'(i)));
            exp_wr.push_back({32'(d + 32'(i)), pat(32'(s + 32'(i)))});
        end
    endtask

    task automatic check_sb(input string tag);
        int nw, nr;
        wr_t e;
        logic [31:0] a;
        logic [5:0] p;
        nw = wr_cnt - wr_base;
        nr = rd_cnt - rd_base;
        check({tag, "_nwr"}, 64'(nw), 64'(exp_wr.size()));
        check({tag, "_nrd"}, 64'(nr), 64'(exp_rd.size()));
        for (int j = 0; j < nw && exp_wr.size() > 0; j++) begin
            e = exp_wr.pop_front();
            p = 6'(wr_base + j);
            check({tag, "_wadr"}, 64'(wr_adr_log[p]), 64'(e.adr));
            check({tag, "_wdat"}, 64'(wr_dat_log[p]), 64'(e.dat));
        end
        for (int j = 0; j < nr && exp_rd.size() > 0; j++) begin
            a = exp_rd.pop_front();
            p = 6'(rd_base + j);
            check({tag, "_radr"}, 64'(rd_log[p]), 64'(a));
        end
        exp_wr.delete();
        exp_rd.delete();
    endtask

    // Start at edge 0, observe each cycle k at its falling edge until done (or a reset abort).
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int mid_start, input int rst_at);
        logic prev_stb, stop;
        wr_base = wr_cnt;
        rd_base = rd_cnt;
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        r_done_cyc = -1; r_busy_cyc = 0; r_stb_rise = -1; r_stb_fall = -1;
        r_cyc_seen = 1'b0; r_rst_cyc = 1'b1; r_rst_busy = 1'b1; r_rst_done = 1'b1;
        prev_stb = 1'b0;
        stop = 1'b0;
        for (int k = 1; k <= 200 && r_done_cyc < 0 && !stop; k++) begin
            @(negedge clk);
            if (busy) r_busy_cyc++;
            if (wb_cyc_o) r_cyc_seen = 1'b1;
            if (wb_stb_o && !prev_stb) r_stb_rise = k;
            if (!wb_stb_o && prev_stb) r_stb_fall = k;
            prev_stb = wb_stb_o;
            if (done) r_done_cyc = k;
            if (k == rst_at + 1) begin
                r_rst_cyc  = wb_cyc_o;
                r_rst_busy = busy;
                r_rst_done = done;
                rst  = 1'b0;
                stop = 1'b1;
            end
            if (k == rst_at) rst = 1'b1;
            start = (k == mid_start);
            if (k == mid_start) begin
                src_addr = 32'hDEAD_0000;
                dst_addr = 32'hBEEF_0000;
                len      = 16'd9;
            end
        end
        start = 1'b0;
        @(negedge clk);
        r_busy_after = busy;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        src_addr = 32'h0; dst_addr = 32'h0; len = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {58'h0, busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o}, 64'h0);
        check("rst_xfer", 64'(xfer_count), 64'h0);
        check("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'h0);
        rst = 1'b0;

        // basic copy with an ignored start mid-transfer
        push_expect(32'h10, 32'h40, 4);
        run_copy(32'h10, 32'h40, 16'd4, 5, -10);
        check("t1_done_cyc", 64'(r_done_cyc), 64'd25);
        check("t1_busy_cyc", 64'(r_busy_cyc), 64'd25);
        check("t1_busy_after", 64'(r_busy_after), 64'd0);
        check("t1_xfer", 64'(xfer_count), 64'd4);
        check("t1_err", 64'(err), 64'd0);
        check_sb("t1");

        // zero length
        run_copy(32'h10, 32'h40, 16'd0, -10, -10);
        check("t2_done_cyc", 64'(r_done_cyc), 64'd1);
        check("t2_busy_cyc", 64'(r_busy_cyc), 64'd1);
        check("t2_cyc_seen", 64'(r_cyc_seen), 64'd0);
        check("t2_busy_after", 64'(r_busy_after), 64'd0);
        check_sb("t2");

        // timeout on the second read
        withhold_at = rd_cnt + 1;
        push_expect(32'h20, 32'h60, 1);
        run_copy(32'h20, 32'h60, 16'd3, -10, -10);
        withhold_at = -1;
        check("t3_stb_rise", 64'(r_stb_rise), 64'd7);
        check("t3_stb_fall", 64'(r_stb_fall), 64'd15);
        check("t3_done_cyc", 64'(r_done_cyc), 64'd15);
        check("t3_err", 64'(err), 64'd1);
        check("t3_xfer", 64'(xfer_count), 64'd1);
        check_sb("t3");

        // good responder again clears err
        push_expect(32'h30, 32'h70, 2);
        run_copy(32'h30, 32'h70, 16'd2, -10, -10);
        check("t3b_err", 64'(err), 64'd0);
        check("t3b_done_cyc", 64'(r_done_cyc), 64'd13);
        check("t3b_xfer", 64'(xfer_count), 64'd2);
        check_sb("t3b");

        // ack held one cycle past the strobe
        hold_mode = 1'b1;
        push_expect(32'h08, 32'h50, 3);
        run_copy(32'h08, 32'h50, 16'd3, -10, -10);
        hold_mode = 1'b0;
        check("t4_done_cyc", 64'(r_done_cyc), 64'd19);
        check("t4_xfer", 64'(xfer_count), 64'd3);
        check_sb("t4");

        // source address wrap-around
        push_expect(32'hFFFF_FFFE, 32'h80, 4);
        run_copy(32'hFFFF_FFFE, 32'h80, 16'd4, -10, -10);
        check("t5_rd2_wrap", 64'(rd_log[6'(rd_base + 2)]), 64'h0);
        check("t5_done_cyc", 64'(r_done_cyc), 64'd25);
        check_sb("t5");

        // reset pulse in cycle 9
        run_copy(32'h10, 32'hC0, 16'd4, -10, 9);
        check("t6_rst_cyc", 64'(r_rst_cyc), 64'd0);
        check("t6_rst_busy", 64'(r_rst_busy), 64'd0);
        check("t6_rst_done", 64'(r_rst_done), 64'd0);
        check("t6_no_done", 64'(r_done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_rst_xfer", 64'(xfer_count), 64'd0);

        // normal run right after the reset
        push_expect(32'h18, 32'h90, 4);
        run_copy(32'h18, 32'h90, 16'd4, 10, -10);
        check("t7_done_cyc", 64'(r_done_cyc), 64'd25);
        check("t7_xfer", 64'(xfer_count), 64'd4);
        check("t7_err", 64'(err), 64'd0);
        check_sb("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_copy_master.md
Name: wb_copy_master

Overview:
- Wishbone classic initiator that copies a block of words from a source region to a destination region on the system bus.
- Each word is one single read cycle followed by one single write cycle.
- Started by the CNN controller or CPU-side sequencer; drives the shared Wishbone fabric toward the memory and GPIO responders.
- Provides a per-access ack timeout and a sticky error flag.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width; addresses are word addresses.
- DATA_WIDTH, 32, Wishbone data width.
- LEN_WIDTH, 16, width of the transfer-length field in words.
- TIMEOUT, 255, maximum cycles with stb high and no ack before an access aborts.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  first source word address, latched on start.
- dst_addr  in  ADDR_WIDTH  first destination word address, latched on start.
- len  in  LEN_WIDTH  word count, latched on start.
- busy  out  1  high from the cycle after start through the DONE cycle.
- done  out  1  one-cycle pulse at completion or abort.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- xfer_count  out  LEN_WIDTH  number of words fully written so far.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  ADDR_WIDTH  address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack_i  in  1  responder acknowledge.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal index/buffer/timer cleared.
- rst mid-transfer: cyc/stb/we drop at that edge, no done pulse, err cleared.
- All Wishbone outputs are registered.
- FSM states: IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
- IDLE:
  - start=1 with len!=0: latch src/dst/len, clear err and xfer_count, go RD.
  - start=1 with len=0: go DONE directly, with no bus activity.
- RD: cyc=1, stb=1, we=0, adr=src+i.
  - On ack: capture wb_dat_i into the data buffer, go RD_GAP.
- RD_GAP: cyc=1, stb=0. wb_ack_i is ignored here, because a responder may hold ack one extra cycle. Go WR.
- WR: cyc=1, stb=1, we=1, adr=dst+i, dat_o=buffer.
  - On ack: xfer_count<=i+1, i<=i+1, go WR_GAP.
- WR_GAP: cyc=1, stb=0, ack ignored.
  - If i==len, go DONE; else go RD.
- DONE: cyc=0, stb=0, done=1 for exactly one cycle, busy=1. Then go IDLE, where busy=0.
- Address arithmetic: src+i and dst+i are computed modulo 2^ADDR_WIDTH, so wrap-around is silent.
- Timer: resets on entry to RD/WR and counts while stb=1 without ack.
  - When the count reaches TIMEOUT: err<=1, drop cyc/stb, go DONE. xfer_count keeps the count of completed words.
- Ack arriving in the same cycle the timer expires: the ack wins and the transfer continues.
- start while busy: ignored, with no effect on the latched fields.
- Cycle timing with a 1-cycle-ack responder, where start is sampled at edge 0:
  - RD stb is high in cycle 1; ack arrives in cycle 2.
  - Each word takes 6 cycles.
  - cyc is high through cycle 6N.
  - done pulses in cycle 6N+1; busy falls in cycle 6N+2.
- With slower responders, each extra wait cycle extends RD/WR by one cycle.

Decomposition:
- Package wb_copy_pkg holds:
  - the state enum (IDLE, RD, RD_GAP, WR, WR_GAP, DONE);
  - the default TIMEOUT constant;
  - the state-width constant.
- One sub-module is natural: wb_ack_timer, a loadable down-counter with clear, enable and expire outputs.
- The datapath (index, buffer, address adders) stays in the top module.

Test Plan:
- Copy, len=4, src=0x10, dst=0x40: source holds A0..A3 and the responder acks in 1 cycle.
  - Required: dst words 0x40..0x43 equal A0..A3.
  - Required: done in cycle 25, xfer_count=4, err=0.
- len=0 with start:
  - Required: done pulses in cycle 1, wb_cyc_o never rises, busy high for 1 cycle only.
- Responder withholds ack on the 2nd read, with TIMEOUT=8:
  - Required: stb drops 8 cycles after it rose, err=1, done pulses, xfer_count=1.
  - Then a new start with a good responder: err clears.
- Responder holds ack high one extra cycle after stb drops:
  - Required: no double capture, no skipped word; data correct for len=3.
- Wrap-around, src=0xFFFF_FFFE, len=4:
  - Required: read addresses are 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1.
- Pulse rst in cycle 9 of a len=4 transfer:
  - Required: cyc=0 the cycle after, busy=0, no done pulse.
  - A start 2 cycles later runs normally.
  - Also: start asserted mid-transfer is ignored.
